if_stage: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the decode stage and drives its ifid_t input.
- Owns the PC and issues pipelined requests over a valid/ready instruction-memory interface (up to MAX_OUTSTANDING in flight).
- Buffers responses in a small fetch FIFO and presents one instruction per cycle to decode.
- Handles branch/jump redirects from execute by discarding stale in-flight responses using an epoch bit.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/if_stage.sv | 101 ++++++++++
 tb/tb_if_stage.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline types and constants for the fetch/decode boundary
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } ifid_t;
  typedef struct packed {
    logic            epoch;
    logic [XLEN-1:0] pc;
  } fetch_tag_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of any type with clear, count and flags
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter type T = logic,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  T              wdata,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  T mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // flags and gated handshakes
  always_comb begin
    empty   = count == '0;
    full    = count == CW'(DEPTH);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem[rd];
  end
  // pointers and occupancy; clear empties the queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (clear) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= inc(wr);
      if (do_pop) rd <= inc(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset; occupancy qualifies every read
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr] <= wdata;
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with pipelined imem requests, epoch-tagged redirects and a fetch buffer; IF_PERF_CNT_EN adds perf counters
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int MAX_OUTSTANDING = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output ifid_t           outputs,
  output logic            ValidD
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall
`endif
);
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BCW = $clog2(FIFO_DEPTH + 1);
  logic [XLEN-1:0] pcf;
  logic epoch, pend;
  logic fire, rsp, keep, clr, pop_buf;
  fetch_tag_t trk_in, trk_head;
  ifid_t buf_in, buf_head;
  logic trk_full, trk_empty, buf_full, buf_empty;
  logic [TCW-1:0] trk_count;
  logic [BCW-1:0] buf_count;
  // issue credit, response filtering and decode-side view of the buffer head
  always_comb begin
    imem_req_valid = reset && !PCSrcE && (pend || (!StallF
                     && int'(trk_count) + int'(buf_count) < FIFO_DEPTH
                     && int'(trk_count) < MAX_OUTSTANDING));
    imem_addr = pcf;
    fire      = imem_req_valid && imem_req_ready;
    rsp       = imem_rsp_valid && !trk_empty;
    clr       = PCSrcE || FlushD;
    keep      = rsp && trk_head.epoch == epoch && !clr;
    pop_buf   = !StallD && !buf_empty;
    trk_in    = '{epoch: epoch, pc: pcf};
    buf_in    = '{instr: imem_rsp_data, pc: trk_head.pc, pcplus4: trk_head.pc + XLEN'(4)};
    ValidD    = !buf_empty;
    outputs   = buf_empty ? ifid_t'{instr: NOP_INSTR, pc: '0, pcplus4: '0} : buf_head;
  end
  // PC, epoch and the offered-but-not-accepted flag that pins valid/addr
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcf   <= RESET_PC;
      epoch <= 1'b0;
      pend  <= 1'b0;
    end else if (PCSrcE) begin
      pcf   <= word_align(PCTargetE);
      epoch <= !epoch;
      pend  <= 1'b0;
    end else begin
      pend <= imem_req_valid && !imem_req_ready;
      if (fire) pcf <= pcf + XLEN'(4);
    end
  end
  fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .T(fetch_tag_t)) u_track (
    .clk(clk), .reset(reset), .push(fire), .pop(rsp), .clear(1'b0),
    .wdata(trk_in), .rdata(trk_head), .full(trk_full), .empty(trk_empty), .count(trk_count)
  );
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(ifid_t)) u_ibuf (
    .clk(clk), .reset(reset), .push(keep), .pop(pop_buf), .clear(clr),
    .wdata(buf_in), .rdata(buf_head), .full(buf_full), .empty(buf_empty), .count(buf_count)
  );
  // credit rule makes these unreachable; catch memory-model or credit bugs in simulation
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(rsp && buf_full));
      assert (!(imem_rsp_valid && trk_empty));
      assert (!(fire && trk_full));
    end
  end
`ifdef IF_PERF_CNT_EN
  // saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(keep && !(&perf_fetched));
      perf_dropped <= perf_dropped + 32'(rsp && !keep && !(&perf_dropped));
      perf_stall   <= perf_stall + 32'(!ValidD && !StallD && !(&perf_stall));
    end
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed checks of if_stage against a queue-based fetch model
module tb_if_stage;
  import pipeline_pkg::*;
  localparam int DEPTH = 2;
  localparam int MAXO = 2;
  logic clk = 0, reset = 0, StallF = 0, StallD = 0, FlushD = 0, PCSrcE = 0;
  logic imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] PCTargetE = '0, imem_rsp_data = '0, imem_addr;
  logic imem_req_valid, ValidD;
  ifid_t outputs;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif
  if_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .outputs(outputs), .ValidD(ValidD)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped), .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; bit stale;} fl_t;
  fl_t m_fl[$];
  logic [31:0] m_buf[$];
  logic [31:0] m_pc;
  bit m_pend;
  int m_fetched, m_dropped, m_stall;
  logic e_valid, e_vd;
  ifid_t e_out;
  int vecs = 0, errs = 0;
  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction
  task automatic model_reset();
    m_fl.delete(); m_buf.delete(); m_pc = 0; m_pend = 0;
    m_fetched = 0; m_dropped = 0; m_stall = 0;
  endtask
  task automatic apply(input bit sf, sd, fd, ps, input logic [31:0] tgt, input bit rdy, rv);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt; imem_req_ready = rdy;
    imem_rsp_valid = rv && m_fl.size() > 0;
    imem_rsp_data = imem_rsp_valid ? mem_of(m_fl[0].pc) : $urandom;
    e_valid = !ps && (m_pend || (!sf && m_fl.size() + m_buf.size() < DEPTH && m_fl.size() < MAXO));
    e_vd = m_buf.size() > 0;
    e_out = e_vd ? ifid_t'{mem_of(m_buf[0]), m_buf[0], m_buf[0] + 32'd4} : ifid_t'{NOP_INSTR, 32'd0, 32'd0};
    #1;
  endtask
  task automatic advance();
    fl_t h;
    bit fire, keep;
    @(posedge clk);
    fire = e_valid && imem_req_ready;
    keep = 0;
    if (imem_rsp_valid) begin
      h = m_fl.pop_front();
      keep = !h.stale && !PCSrcE && !FlushD;
      if (keep) m_fetched++; else m_dropped++;
    end
    if (!e_vd && !StallD) m_stall++;
    if (PCSrcE || FlushD) m_buf.delete();
    else begin
      if (!StallD && m_buf.size() > 0) m_buf.delete(0);
      if (keep) m_buf.push_back(h.pc);
    end
    if (PCSrcE) begin
      foreach (m_fl[i]) m_fl[i].stale = 1;
      m_pc = PCTargetE & ~32'h3;
      m_pend = 0;
    end else if (fire) begin
      m_fl.push_back('{m_pc, 1'b0});
      m_pc += 4;
      m_pend = 0;
    end else m_pend = e_valid;
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; imem_req_ready = 0; imem_rsp_valid = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1;
  endtask
  task automatic test_reset();
    #1;
    vecs++;
    if (imem_req_valid !== 1'b0 || ValidD !== 1'b0 || outputs !== ifid_t'{NOP_INSTR, 32'd0, 32'd0}) begin
      errs++; $display("FAIL reset_async: valid=%b vd=%b out=%h", imem_req_valid, ValidD, outputs);
    end
    @(posedge clk);
    @(negedge clk);
    vecs++;
    if (imem_req_valid !== 1'b0 || ValidD !== 1'b0) begin
      errs++; $display("FAIL reset_held: valid=%b vd=%b, want 0 0", imem_req_valid, ValidD);
    end
    reset = 1;
    model_reset();
    apply(0, 0, 0, 0, 0, 0, 0);
    vecs++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      errs++; $display("FAIL reset_first_req: valid=%b addr=%h, want 1 00000000", imem_req_valid, imem_addr);
    end
    advance();
  endtask
  task automatic test_stream();
    logic [31:0] nxt = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      apply(0, 0, 0, 0, 0, 1, 1);
      vecs++;
      if ({imem_req_valid, ValidD, outputs} !== {e_valid, e_vd, e_out} || (e_valid && imem_addr !== m_pc)) begin
        errs++; $display("FAIL stream c%0d: valid=%b addr=%h vd=%b out=%h, want %b %h %b %h", i, imem_req_valid, imem_addr, ValidD, outputs, e_valid, m_pc, e_vd, e_out);
      end
      if (ValidD) begin
        vecs++;
        if (outputs.pc !== nxt) begin errs++; $display("FAIL stream_seq c%0d: pc=%h, want %h", i, outputs.pc, nxt); end
        nxt += 4;
      end
      advance();
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] acc = 0;
    bit hit = 0;
    do_reset();
    for (int i = 0; i < 20 && !hit; i++) begin
      apply(0, 0, 0, 0, 0, m_pc != 32'h8, 1);
      if (imem_req_valid && imem_req_ready) begin
        vecs++;
        if (imem_addr !== acc) begin errs++; $display("FAIL bp_pre_seq: addr=%h, want %h", imem_addr, acc); end
        acc += 4;
      end
      hit = !imem_req_ready && e_valid;
      if (!hit) advance();
    end
    if (!hit) begin errs++; $display("FAIL bp_reach: no request offered at 00000008, want one"); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) apply(k == 1, 0, 0, 0, 0, 0, 1);
      vecs++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin
        errs++; $display("FAIL bp_hold k%0d: valid=%b addr=%h, want 1 00000008", k, imem_req_valid, imem_addr);
      end
      advance();
    end
    for (int i = 0; i < 12; i++) begin
      apply(0, 0, 0, 0, 0, 1, 1);
      vecs++;
      if ({imem_req_valid, ValidD, outputs} !== {e_valid, e_vd, e_out} || (e_valid && imem_addr !== m_pc)) begin
        errs++; $display("FAIL bp_resume c%0d: valid=%b addr=%h vd=%b out=%h, want %b %h %b %h", i, imem_req_valid, imem_addr, ValidD, outputs, e_valid, m_pc, e_vd, e_out);
      end
      if (imem_req_valid && imem_req_ready) begin
        vecs++;
        if (imem_addr !== acc) begin errs++; $display("FAIL bp_seq c%0d: addr=%h, want %h", i, imem_addr, acc); end
        acc += 4;
      end
      advance();
    end
  endtask
  task automatic test_redirect();
    bit got = 0;
    logic [31:0] acc = 32'h10;
    do_reset();
    for (int i = 0; i < 30 && m_pc != 32'h10; i++) begin apply(0, 0, 0, 0, 0, 1, 1); advance(); end
    for (int i = 0; i < 10 && (m_fl.size() > 0 || m_buf.size() > 0); i++) begin apply(0, 0, 0, 0, 0, 0, 1); advance(); end
    for (int i = 0; i < 10 && m_fl.size() < 2; i++) begin
      apply(0, 0, 0, 0, 0, 1, 0);
      if (imem_req_valid) begin
        vecs++;
        if (imem_addr !== acc) begin errs++; $display("FAIL redir_inflight: addr=%h, want %h", imem_addr, acc); end
        acc += 4;
      end
      advance();
    end
    apply(0, 0, 0, 1, 32'h102, 1, 1);
    vecs++;
    if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL redir_valid: valid=%b, want 0", imem_req_valid); end
    advance();
    for (int i = 0; i < 10 && !got; i++) begin
      apply(0, 0, 0, 0, 0, 1, 1);
      vecs++;
      if ({imem_req_valid, ValidD, outputs} !== {e_valid, e_vd, e_out} || (e_valid && imem_addr !== m_pc)) begin
        errs++; $display("FAIL redir_model c%0d: valid=%b addr=%h vd=%b out=%h, want %b %h %b %h", i, imem_req_valid, imem_addr, ValidD, outputs, e_valid, m_pc, e_vd, e_out);
      end
      if (ValidD) begin
        got = 1;
        vecs++;
        if (outputs.pc !== 32'h100 || outputs.instr !== mem_of(32'h100)) begin
          errs++; $display("FAIL redir_target: pc=%h instr=%h, want 00000100 %h", outputs.pc, outputs.instr, mem_of(32'h100));
        end
      end
      advance();
    end
    if (!got) begin errs++; $display("FAIL redir_timeout: ValidD never set, want target delivered"); end
`ifdef IF_PERF_CNT_EN
    vecs++;
    if (perf_dropped !== 32'd2) begin errs++; $display("FAIL redir_perf_dropped: %0d, want 2", perf_dropped); end
`endif
  endtask
  task automatic test_stalld();
    ifid_t held;
    logic [31:0] nxt;
    do_reset();
    for (int i = 0; i < 20 && !(e_vd && i > 4); i++) begin apply(0, 0, 0, 0, 0, 1, 1); advance(); apply(0, 0, 0, 0, 0, 1, 1); end
    held = outputs;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) apply(0, 1, 0, 0, 0, 1, 1);
      else StallD = 1;
      vecs++;
      if (ValidD !== 1'b1 || outputs !== held) begin
        errs++; $display("FAIL stalld_frozen k%0d: vd=%b out=%h, want 1 %h", k, ValidD, outputs, held);
      end
      advance();
    end
    apply(0, 1, 0, 0, 0, 1, 1);
    vecs++;
    if (imem_req_valid !== 1'b0 || m_buf.size() != 2) begin
      errs++; $display("FAIL stalld_full: valid=%b modelbuf=%0d, want 0 2", imem_req_valid, m_buf.size());
    end
    advance();
    nxt = held.pc;
    for (int i = 0; i < 12; i++) begin
      apply(0, 0, 0, 0, 0, 1, 1);
      vecs++;
      if ({imem_req_valid, ValidD, outputs} !== {e_valid, e_vd, e_out} || (e_valid && imem_addr !== m_pc)) begin
        errs++; $display("FAIL stalld_model c%0d: valid=%b addr=%h vd=%b out=%h, want %b %h %b %h", i, imem_req_valid, imem_addr, ValidD, outputs, e_valid, m_pc, e_vd, e_out);
      end
      if (ValidD) begin
        vecs++;
        if (outputs.pc !== nxt) begin errs++; $display("FAIL stalld_seq c%0d: pc=%h, want %h", i, outputs.pc, nxt); end
        nxt += 4;
      end
      advance();
    end
  endtask
  task automatic test_flushd();
    bit tsd[6] = '{0, 1, 1, 0, 0, 0};
    bit tfd[6] = '{0, 0, 0, 1, 0, 0};
    bit trd[6] = '{1, 0, 1, 1, 0, 0};
    bit trv[6] = '{0, 1, 0, 0, 1, 0};
    logic [31:0] want;
    bit got = 0;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      apply(0, tsd[s], tfd[s], 0, 0, trd[s], trv[s]);
      vecs++;
      if ({imem_req_valid, ValidD, outputs} !== {e_valid, e_vd, e_out} || (e_valid && imem_addr !== m_pc)) begin
        errs++; $display("FAIL flush_inflight s%0d: valid=%b addr=%h vd=%b out=%h, want %b %h %b %h", s, imem_req_valid, imem_addr, ValidD, outputs, e_valid, m_pc, e_vd, e_out);
      end
      if (s == 5) begin
        vecs++;
        if (ValidD !== 1'b1 || outputs.pc !== 32'h4) begin
          errs++; $display("FAIL flush_keep: vd=%b pc=%h, want 1 00000004", ValidD, outputs.pc);
        end
      end
      advance();
    end
    for (int i = 0; i < 10 && m_buf.size() < 2; i++) begin apply(0, 1, 0, 0, 0, 1, 1); advance(); end
    apply(0, 0, 1, 0, 0, 1, 1);
    want = m_pc;
    advance();
    apply(0, 0, 0, 0, 0, 1, 1);
    vecs++;
    if (ValidD !== 1'b0 || outputs.instr !== NOP_INSTR) begin
      errs++; $display("FAIL flush_bubble: vd=%b instr=%h, want 0 %h", ValidD, outputs.instr, NOP_INSTR);
    end
    advance();
    for (int i = 0; i < 10 && !got; i++) begin
      apply(0, 0, 0, 0, 0, 1, 1);
      if (ValidD) begin
        got = 1;
        vecs++;
        if (outputs.pc !== want) begin errs++; $display("FAIL flush_resume: pc=%h, want %h", outputs.pc, want); end
      end
      advance();
    end
    if (!got) begin errs++; $display("FAIL flush_timeout: ValidD never set after flush"); end
  endtask
  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 20 && !(e_vd && i > 3); i++) begin apply(0, 0, 0, 0, 0, 1, 1); advance(); end
    @(posedge clk);
    #2;
    reset = 0; imem_rsp_valid = 0; imem_req_ready = 0;
    #1;
    vecs++;
    if (imem_req_valid !== 1'b0 || ValidD !== 1'b0) begin
      errs++; $display("FAIL async_reset: valid=%b vd=%b, want 0 0", imem_req_valid, ValidD);
    end
    model_reset();
    @(negedge clk);
    reset = 1;
    apply(0, 0, 0, 0, 0, 1, 1);
    vecs++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || ValidD !== 1'b0) begin
      errs++; $display("FAIL async_restart: valid=%b addr=%h vd=%b, want 1 00000000 0", imem_req_valid, imem_addr, ValidD);
    end
    advance();
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      apply($urandom % 5 == 0, $urandom % 4 == 0, $urandom % 16 == 0, $urandom % 20 == 0,
            $urandom, $urandom % 4 != 0, $urandom % 3 != 0);
      vecs++;
      if ({imem_req_valid, ValidD, outputs} !== {e_valid, e_vd, e_out} || (e_valid && imem_addr !== m_pc)) begin
        errs++; $display("FAIL random c%0d: valid=%b addr=%h vd=%b out=%h, want %b %h %b %h", i, imem_req_valid, imem_addr, ValidD, outputs, e_valid, m_pc, e_vd, e_out);
      end
`ifdef IF_PERF_CNT_EN
      vecs++;
      if (perf_fetched !== 32'(m_fetched) || perf_dropped !== 32'(m_dropped) || perf_stall !== 32'(m_stall)) begin
        errs++; $display("FAIL random_perf c%0d: %0d %0d %0d, want %0d %0d %0d", i, perf_fetched, perf_dropped, perf_stall, m_fetched, m_dropped, m_stall);
      end
`endif
      advance();
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_stalld();
    test_flushd();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
